// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between an instruction fetch
// requester and a data load/store requester, with starvation guard and timeout.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic        stall_o
);

  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned STARVE_W = 3;
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t              state, state_d;
  logic [STARVE_W-1:0] starve_cnt, starve_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic                ce_d, we_d, if_ready_d, d_ready_d, err_d;
  logic [31:0]         addr_d, wdata_d, if_rdata_d, d_rdata_d;

  // Registered state and outputs; reset abandons any access without a ready pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      wait_cnt   <= wait_d;
      mem_ce     <= ce_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      if_ready   <= if_ready_d;
      d_ready    <= d_ready_d;
      err        <= err_d;
      if_rdata   <= if_rdata_d;
      d_rdata    <= d_rdata_d;
    end
  end

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d    = state;
    starve_d   = starve_cnt;
    wait_d     = wait_cnt;
    ce_d       = mem_ce;
    we_d       = mem_we;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;

    unique case (state)
      IDLE: begin
        // A ready pulse marks a turnaround cycle: its requester is still holding
        // the completed request, so nothing is granted until it has seen ready.
        if (!if_ready && !d_ready) begin
          if (if_req && (starve_cnt == STARVE_MAX || !d_req)) begin
            state_d  = BUSY_IF;
            starve_d = '0;
            wait_d   = '0;
            ce_d     = 1'b1;
            we_d     = 1'b0;
            addr_d   = if_addr;
          end else if (d_req) begin
            state_d  = BUSY_D;
            wait_d   = '0;
            ce_d     = 1'b1;
            we_d     = d_we;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            if (!if_req)
              starve_d = '0;
            else if (starve_cnt < STARVE_MAX)
              starve_d = starve_cnt + STARVE_W'(1);
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack || wait_cnt == WAIT_LAST) begin
          state_d = IDLE;
          ce_d    = 1'b0;
          err_d   = !mem_ack;
          if (state == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ce_d    = 1'b0;
      end
    endcase
  end

  assign stall_o = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, timeout, reset abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_ce, mem_we, err, stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MAX_WAIT(15), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ce_cycles;
    logic exp_if [6];
    exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ce",     32'(mem_ce),   32'd0);
    chk("rst_ready",  32'({if_ready, d_ready, err}), 32'd0);
    chk("rst_addr",   mem_addr,      32'd0);
    chk("rst_rdata",  if_rdata | d_rdata, 32'd0);
    chk("rst_stall",  32'(stall_o),  32'd0);
    rst = 1'b1;

    // Fetch only, ack one cycle after mem_ce rises
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hCAFE0001;
    #1 chk("f_stall_pend", 32'(stall_o), 32'd1);
    tick();
    chk("f_ce",   32'(mem_ce), 32'd1);
    chk("f_addr", mem_addr,    32'h100);
    chk("f_we",   32'(mem_we), 32'd0);
    mem_ack = 1'b1;
    tick();
    chk("f_ready", 32'(if_ready), 32'd1);
    chk("f_rdata", if_rdata,      32'hCAFE0001);
    chk("f_err",   32'(err),      32'd0);
    chk("f_ce_off", 32'(mem_ce),  32'd0);
    chk("f_stall_rdy", 32'(stall_o), 32'd0);
    if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    chk("f_ready_pulse", 32'(if_ready), 32'd0);
    chk("f_rdata_hold",  if_rdata,      32'hCAFE0001);

    // Simultaneous requests: data store wins, then fetch
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    tick();
    chk("p_addr_d", mem_addr,     32'h20);
    chk("p_we_d",   32'(mem_we),  32'd1);
    chk("p_wdata",  mem_wdata,    32'hDEADBEEF);
    d_wdata = 32'h0;
    tick();
    chk("p_stable_ce",    32'(mem_ce), 32'd1);
    chk("p_stable_wdata", mem_wdata,   32'hDEADBEEF);
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    tick();
    chk("p_d_ready", 32'(d_ready), 32'd1);
    chk("p_d_rdata", d_rdata,      32'h55AA55AA);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("p_turnaround_ce", 32'(mem_ce), 32'd0);
    tick();
    chk("p_addr_i", mem_addr,    32'h200);
    chk("p_we_i",   32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    chk("p_if_ready", 32'(if_ready), 32'd1);
    chk("p_if_rdata", if_rdata,      32'h12345678);
    chk("p_d_hold",   d_rdata,       32'h55AA55AA);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Continuous requests, ack held high (ignored in IDLE): D,D,I,D,D,I
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("s_grant_ce", 32'(mem_ce), 32'd1);
      chk("s_grant_addr", mem_addr, exp_if[g] ? 32'h300 : 32'h40);
      tick();
      chk("s_ready", 32'({if_ready, d_ready}), exp_if[g] ? 32'd2 : 32'd1);
      chk("s_stall", 32'(stall_o), 32'd1);
      tick();
      chk("s_gap_ce", 32'(mem_ce), 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Timeout: no ack ever
    d_req = 1'b1; d_addr = 32'h80; mem_rdata = 32'hFFFFFFFF;
    tick();
    ce_cycles = mem_ce ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_ce) ce_cycles++;
      else break;
    end
    chk("t_ce_cycles", 32'(ce_cycles), 32'd15);
    chk("t_d_ready",   32'(d_ready),   32'd1);
    chk("t_err",       32'(err),       32'd1);
    chk("t_d_rdata",   d_rdata,        32'd0);
    chk("t_if_hold",   if_rdata,       32'h0BADF00D);
    d_req = 1'b0;
    tick();
    chk("t_err_pulse", 32'(err),    32'd0);
    chk("t_idle_ce",   32'(mem_ce), 32'd0);

    // Reset in the middle of a data access
    d_req = 1'b1; d_addr = 32'h90;
    tick();
    chk("r_ce_busy", 32'(mem_ce), 32'd1);
    #2 rst = 1'b0;
    #1 chk("r_ce_async", 32'(mem_ce), 32'd0);
    tick();
    chk("r_no_ready", 32'({d_ready, err}), 32'd0);
    chk("r_addr_clr", mem_addr, 32'd0);
    chk("r_stall",    32'(stall_o), 32'd1);
    rst = 1'b1;
    tick();
    chk("r_regrant_ce",   32'(mem_ce), 32'd1);
    chk("r_regrant_addr", mem_addr,    32'h90);
    mem_ack = 1'b1; mem_rdata = 32'h00C0FFEE;
    tick();
    chk("r_d_ready", 32'(d_ready), 32'd1);
    chk("r_d_rdata", d_rdata,      32'h00C0FFEE);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("r_stall_idle", 32'(stall_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15: cycles a granted access waits for mem_ack before it aborts (range 1..255).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 2: consecutive data grants allowed while the fetch request waits (range 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port if_req, input, 1 bit: fetch request, held until if_ready.
REQ-006 The block SHALL have port if_addr, input, 32 bits: fetch address.
REQ-007 The block SHALL have ports if_rdata (output, 32 bits) and if_ready (output, 1 bit): fetch data and one-cycle completion pulse.
REQ-008 The block SHALL have ports d_req, d_we (input, 1 bit each): data request, held until d_ready, and its write enable.
REQ-009 The block SHALL have ports d_addr, d_wdata (input, 32 bits each): data address and store data.
REQ-010 The block SHALL have ports d_rdata (output, 32 bits) and d_ready (output, 1 bit): load data and one-cycle completion pulse.
REQ-011 The block SHALL have ports mem_ce, mem_we (output, 1 bit each): shared memory chip enable and write enable.
REQ-012 The block SHALL have ports mem_addr, mem_wdata (output, 32 bits each): memory address and write data.
REQ-013 The block SHALL have ports mem_rdata (input, 32 bits) and mem_ack (input, 1 bit): memory read data and access-complete flag.
REQ-014 The block SHALL have port err, output, 1 bit: asserted with a ready pulse when the access timed out.
REQ-015 The block SHALL have port stall_o, output, 1 bit: pipeline hold.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY_IF and BUSY_D.
REQ-017 In IDLE with a request, the arbiter SHALL select a requester at the clock edge, register address, write enable and write data, and enter the matching BUSY state.
REQ-018 Selection SHALL favour data over fetch, except fetch SHALL win once starve_cnt equals STARVE_LIMIT.
REQ-019 starve_cnt SHALL be a 3-bit counter, incremented on a data grant while if_req=1, cleared on any fetch grant and on a data grant while if_req=0, and saturating at STARVE_LIMIT.
REQ-020 In IDLE, a requester whose ready is high in that cycle SHALL NOT be granted, preventing a double grant of a completed request.
REQ-021 mem_ce SHALL be 1 exactly while in BUSY_IF or BUSY_D; mem_addr, mem_we and mem_wdata SHALL be the registered values and stay stable throughout BUSY.
REQ-022 mem_we SHALL be 0 in BUSY_IF.
REQ-023 A wait counter SHALL be cleared on grant and incremented each BUSY cycle with mem_ack=0.
REQ-024 When mem_ack=1 in BUSY, the arbiter SHALL capture mem_rdata into if_rdata or d_rdata and pulse the matching ready for the next cycle only, with err=0, and SHALL return to IDLE.
REQ-025 When the wait counter reaches MAX_WAIT with mem_ack=0, the arbiter SHALL return to IDLE and pulse the matching ready with err=1 and rdata=0.
REQ-026 if_rdata and d_rdata SHALL hold their last captured value between completions.
REQ-027 An access SHALL complete no earlier than 2 cycles from request, and back-to-back throughput SHALL be no better than one access per 3 cycles with a 1-cycle ack.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 stall_o SHALL be combinational: (if_req & ~if_ready) | (d_req & ~d_ready).

Reset
REQ-030 While rst=0, the block SHALL immediately enter IDLE, regardless of any access in flight, which is abandoned with no ready pulse.
REQ-031 While rst=0, all registered outputs, starve_cnt and the wait counter SHALL be 0.
REQ-032 After rst rises, the first grant SHALL be possible on the first rising edge.

Verification
REQ-033 Fetch only: if_req=1, if_addr=0x100, mem_ack=1 one cycle after mem_ce -> mem_ce/mem_addr=0x100 for 1 cycle, then if_ready=1 with if_rdata=mem_rdata, err=0.
REQ-034 Simultaneous requests with d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> data granted first with mem_we=1 and mem_wdata=0xDEADBEEF, then fetch.
REQ-035 Continuous d_req with if_req held -> after 2 data grants fetch is granted, and the pattern D,D,I repeats.
REQ-036 mem_ack never asserted -> mem_ce high for 15 cycles, then d_ready=1, err=1, d_rdata=0, and the FSM is in IDLE.
REQ-037 rst=0 asserted mid-BUSY_D -> mem_ce=0 asynchronously, no d_ready pulse, and the retried request is granted on the first edge after release.
REQ-038 Check stall_o=1 on every cycle a request is pending without its ready, and 0 otherwise.
